// File: rtl/traffic_phase_timer.sv
// Two-way intersection phase sequencer: 1 s prescaler, six-phase FSM, per-phase
// countdown and pedestrian green truncation. Define TRAFFIC_NIGHT_FLASH_EN for night flashing.
module traffic_phase_timer #(
  parameter int pNUMBER_WIDTH = 5,
  parameter int pTICK_DIV     = 50000000,
  parameter int pGREEN_TIME   = 25,
  parameter int pYELLOW_TIME  = 3,
  parameter int pALLRED_TIME  = 2,
  parameter int pPED_MIN      = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic                     night,
`endif
  output logic [2:0]               ns_light,
  output logic [2:0]               ew_light,
  output logic [pNUMBER_WIDTH-1:0] number,
  output logic                     en,
  output logic                     phase_start
);

  localparam int TICK_W = (pTICK_DIV > 2) ? $clog2(pTICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(pTICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  localparam logic [pNUMBER_WIDTH-1:0] NUM_ONE   = pNUMBER_WIDTH'(1);
  localparam logic [pNUMBER_WIDTH-1:0] GREEN_N   = pNUMBER_WIDTH'(pGREEN_TIME);
  localparam logic [pNUMBER_WIDTH-1:0] YELLOW_N  = pNUMBER_WIDTH'(pYELLOW_TIME);
  localparam logic [pNUMBER_WIDTH-1:0] ALLRED_N  = pNUMBER_WIDTH'(pALLRED_TIME);
  localparam logic [pNUMBER_WIDTH-1:0] PED_MIN_N = pNUMBER_WIDTH'(pPED_MIN);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [2:0] {
    S_NS_GREEN,
    S_NS_YELLOW,
    S_ALLRED_A,
    S_EW_GREEN,
    S_EW_YELLOW,
    S_ALLRED_B
  } state_t;

  function automatic state_t next_phase(input state_t s);
    case (s)
      S_NS_GREEN:  return S_NS_YELLOW;
      S_NS_YELLOW: return S_ALLRED_A;
      S_ALLRED_A:  return S_EW_GREEN;
      S_EW_GREEN:  return S_EW_YELLOW;
      S_EW_YELLOW: return S_ALLRED_B;
      default:     return S_NS_GREEN;
    endcase
  endfunction

  function automatic logic [pNUMBER_WIDTH-1:0] phase_len(input state_t s);
    case (s)
      S_NS_GREEN, S_EW_GREEN:   return GREEN_N;
      S_NS_YELLOW, S_EW_YELLOW: return YELLOW_N;
      default:                  return ALLRED_N;
    endcase
  endfunction

  function automatic logic [2:0] ns_lamp(input state_t s);
    case (s)
      S_NS_GREEN:  return LAMP_GRN;
      S_NS_YELLOW: return LAMP_YEL;
      default:     return LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input state_t s);
    case (s)
      S_EW_GREEN:  return LAMP_GRN;
      S_EW_YELLOW: return LAMP_YEL;
      default:     return LAMP_RED;
    endcase
  endfunction

  state_t                    state_q, state_d;
  logic [pNUMBER_WIDTH-1:0]  number_q, number_d;
  logic [TICK_W-1:0]         tick_cnt_q, tick_cnt_d;
  logic [2:0]                ns_light_q, ns_light_d;
  logic [2:0]                ew_light_q, ew_light_d;
  logic                      en_q, en_d;
  logic                      phase_start_q, phase_start_d;

  logic sec_tick;
  logic is_green;
  logic ped_cut;
  logic night_hold;
  logic night_enter;
  logic night_exit;

`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic night_mode_q, night_mode_d;
  logic flash_on_q, flash_on_d;
`endif

  always_comb begin
    state_d       = state_q;
    number_d      = number_q;
    tick_cnt_d    = tick_cnt_q;
    phase_start_d = 1'b0;
    en_d          = run;
    sec_tick      = run && (tick_cnt_q == TICK_LAST);
    is_green      = (state_q == S_NS_GREEN) || (state_q == S_EW_GREEN);
    night_hold    = 1'b0;
    night_enter   = 1'b0;
    night_exit    = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    night_mode_d  = night_mode_q;
    flash_on_d    = flash_on_q;
    night_hold    = run && night;
    night_enter   = night_hold && !night_mode_q;
    night_exit    = night_mode_q && !night;
`endif
    ped_cut = run && ped_req && is_green && (number_q > PED_MIN_N) && !night_hold;

    if (run) begin
      tick_cnt_d = sec_tick ? '0 : tick_cnt_q + TICK_ONE;
    end

    if (night_exit) begin
      // Leaving night mode restarts cleanly from the all-red clearance.
      state_d       = S_ALLRED_B;
      number_d      = ALLRED_N;
      phase_start_d = 1'b1;
      tick_cnt_d    = '0;
    end else if (night_hold) begin
      en_d = 1'b0;
      if (night_enter) begin
        tick_cnt_d = '0;
      end
    end else if (ped_cut) begin
      number_d = PED_MIN_N;
    end else if (sec_tick) begin
      if (number_q == NUM_ONE) begin
        state_d       = next_phase(state_q);
        number_d      = phase_len(next_phase(state_q));
        phase_start_d = 1'b1;
      end else begin
        number_d = number_q - NUM_ONE;
      end
    end

    ns_light_d = ns_lamp(state_d);
    ew_light_d = ew_lamp(state_d);

`ifdef TRAFFIC_NIGHT_FLASH_EN
    if (night_exit) begin
      night_mode_d = 1'b0;
      flash_on_d   = 1'b1;
    end else if (night_enter) begin
      night_mode_d = 1'b1;
      flash_on_d   = 1'b1;
    end else if (night_hold && sec_tick) begin
      flash_on_d = ~flash_on_q;
    end
    // Night mode keeps the flash pattern even while run is low.
    if (night_mode_d) begin
      ns_light_d = flash_on_d ? LAMP_YEL : LAMP_OFF;
      ew_light_d = flash_on_d ? LAMP_YEL : LAMP_OFF;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_ALLRED_B;
      number_q      <= ALLRED_N;
      tick_cnt_q    <= '0;
      ns_light_q    <= LAMP_RED;
      ew_light_q    <= LAMP_RED;
      en_q          <= 1'b0;
      phase_start_q <= 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      night_mode_q  <= 1'b0;
      flash_on_q    <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      number_q      <= number_d;
      tick_cnt_q    <= tick_cnt_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
      en_q          <= en_d;
      phase_start_q <= phase_start_d;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      night_mode_q  <= night_mode_d;
      flash_on_q    <= flash_on_d;
`endif
    end
  end

  assign ns_light    = ns_light_q;
  assign ew_light    = ew_light_q;
  assign number      = number_q;
  assign en          = en_q;
  assign phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with a 4-cycle second; inputs driven and
// outputs sampled on the falling clock edge.
module tb_traffic_phase_timer;

  localparam int NW  = 5;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          ped_req = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic          night = 1'b0;
`endif
  logic [2:0]    ns_light;
  logic [2:0]    ew_light;
  logic [NW-1:0] number;
  logic          en;
  logic          phase_start;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .pNUMBER_WIDTH(NW),
    .pTICK_DIV    (DIV),
    .pGREEN_TIME  (25),
    .pYELLOW_TIME (3),
    .pALLRED_TIME (2),
    .pPED_MIN     (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .ped_req    (ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night      (night),
`endif
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .number     (number),
    .en         (en),
    .phase_start(phase_start)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int         dur[6]    = '{25, 3, 2, 25, 3, 2};
  logic [2:0] ns_exp[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_exp[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    // Reset held, run already high
    run = 1'b1;
    cyc(2);
    $display("step: reset values");
    check("rst_ns", ns_light, 3'b100);
    check("rst_ew", ew_light, 3'b100);
    check("rst_number", number, 2);
    check("rst_en", en, 0);
    check("rst_phase_start", phase_start, 0);

    // Release: ALLRED_B for two 4-cycle seconds, then NS_GREEN
    rst_n = 1'b1;
    cyc(1);
    $display("step: reset release");
    check("rel_en", en, 1);
    check("rel_number_c1", number, 2);
    check("rel_ps_c1", phase_start, 0);
    cyc(2);
    check("rel_number_c3", number, 2);
    cyc(1);
    check("rel_number_c4", number, 1);
    check("rel_ns_c4", ns_light, 3'b100);
    cyc(3);
    check("rel_number_c7", number, 1);
    check("rel_ew_c7", ew_light, 3'b100);
    cyc(1);

    // One full cycle, every clock checked
    for (int p = 0; p < 6; p++) begin
      $display("step: phase %0d duration %0d", p, dur[p]);
      for (int v = dur[p]; v >= 1; v--) begin
        for (int c = 0; c < DIV; c++) begin
          check($sformatf("seq_p%0d_v%0d_c%0d_ns", p, v, c), ns_light, ns_exp[p]);
          check($sformatf("seq_p%0d_v%0d_c%0d_ew", p, v, c), ew_light, ew_exp[p]);
          check($sformatf("seq_p%0d_v%0d_c%0d_num", p, v, c), number, v);
          check($sformatf("seq_p%0d_v%0d_c%0d_ps", p, v, c), phase_start,
                (v == dur[p] && c == 0) ? 1 : 0);
          cyc(1);
        end
      end
    end
    check("wrap_ns", ns_light, 3'b001);
    check("wrap_number", number, 25);
    check("wrap_ps", phase_start, 1);

    // Pedestrian truncation at number=20
    cyc(20);
    $display("step: pedestrian request at number=20");
    check("ped_pre_number", number, 20);
    ped_req = 1'b1;
    cyc(1);
    ped_req = 1'b0;
    check("ped_cut_number", number, 5);
    check("ped_cut_ns", ns_light, 3'b001);
    cyc(2);
    check("ped_hold5", number, 5);
    cyc(1);
    check("ped_dec4", number, 4);

    $display("step: pedestrian request at number=4 ignored");
    ped_req = 1'b1;
    cyc(1);
    check("ped_low_hold", number, 4);
    cyc(3);
    check("ped_low_dec", number, 3);
    ped_req = 1'b0;
    cyc(12);
    check("ped_yel_ns", ns_light, 3'b010);
    check("ped_yel_number", number, 3);
    check("ped_yel_ps", phase_start, 1);

    $display("step: pedestrian request in yellow ignored");
    ped_req = 1'b1;
    cyc(4);
    ped_req = 1'b0;
    check("ped_yel_ignored", number, 2);
    check("ped_yel_ns2", ns_light, 3'b010);

    // Advance to EW_GREEN number=12, then freeze mid-second
    cyc(68);
    $display("step: run freeze at EW_GREEN number=12");
    check("frz_pre_ns", ns_light, 3'b100);
    check("frz_pre_ew", ew_light, 3'b001);
    check("frz_pre_number", number, 12);
    cyc(2);
    run = 1'b0;
    ped_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check($sformatf("frz_%0d_number", i), number, 12);
      check($sformatf("frz_%0d_ew", i), ew_light, 3'b001);
      check($sformatf("frz_%0d_en", i), en, 0);
    end
    ped_req = 1'b0;
    run = 1'b1;
    cyc(1);
    check("resume_en", en, 1);
    check("resume_number_c1", number, 12);
    cyc(1);
    check("resume_number_c2", number, 11);

    // Asynchronous reset between clock edges
    $display("step: async reset mid EW_GREEN");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ns", ns_light, 3'b100);
    check("arst_ew", ew_light, 3'b100);
    check("arst_number", number, 2);
    check("arst_en", en, 0);
    check("arst_ps", phase_start, 0);
    cyc(1);
    rst_n = 1'b1;

`ifdef TRAFFIC_NIGHT_FLASH_EN
    cyc(12);
    $display("step: night flashing");
    check("night_pre_number", number, 24);
    night = 1'b1;
    cyc(1);
    check("night_ns_a", ns_light, 3'b010);
    check("night_ew_a", ew_light, 3'b010);
    check("night_en_a", en, 0);
    check("night_number_a", number, 24);
    cyc(3);
    check("night_ns_a_end", ns_light, 3'b010);
    cyc(1);
    check("night_ns_b", ns_light, 3'b000);
    check("night_ew_b", ew_light, 3'b000);
    check("night_number_b", number, 24);
    cyc(4);
    check("night_ns_c", ns_light, 3'b010);
    cyc(4);
    check("night_ns_d", ns_light, 3'b000);
    check("night_en_d", en, 0);
    night = 1'b0;
    cyc(1);
    $display("step: night exit");
    check("nexit_ns", ns_light, 3'b100);
    check("nexit_ew", ew_light, 3'b100);
    check("nexit_number", number, 2);
    check("nexit_ps", phase_start, 1);
    check("nexit_en", en, 1);
    cyc(8);
    check("nexit_green_ns", ns_light, 3'b001);
    check("nexit_green_number", number, 25);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
